rollo_decrypt_sched: RTL and testbench
======================================

ROLLO_DECRYPT_SCHED -- requirements
Module: rollo_decrypt_sched

Interface
REQ-001 SHALL have parameter D, default 6, number of F-space basis elements (dim F); legal range 2..16.
REQ-002 SHALL have parameter TIMEOUT, default 65535, maximum cycles allowed per phase before abort.
REQ-003 SHALL have parameter IW, default CLOG2(D), width of iterate.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_b  input  1  asynchronous, active-high reset (1 = reset).
REQ-006 SHALL have ports start  input  1  request decryption, and busy  output  1  sequence in progress.
REQ-007 SHALL have ports finish  output  1  one-cycle done pulse, and error  output  1  sticky timeout flag.
REQ-008 SHALL have ports gf2mz_start  output  1, and gf2mz_done  input  1  (s = c*x multiplier).
REQ-009 SHALL have ports S1S2gen_start  output  1, and S1S2gen_done  input  1  ([S1,S2] generator).
REQ-010 SHALL have ports RSR_start  output  1, and RSR_done  input  1  (Gaussian elimination).
REQ-011 SHALL have ports sha3_start  output  1, and sha3_done  input  1  (hash).
REQ-012 SHALL have port status  output  3  active phase: 0 idle, 1 gf2mz, 2 S1S2, 3 RSR, 4 SHA3.
REQ-013 SHALL have port iterate  output  IW  current S1S2/RSR round index.
REQ-014 SHALL have ports mat_sel  output  1  (0 when iterate==0, else 1), and is_last  output  1  (1 when iterate==D-2).

Function
REQ-015 SHALL implement FSM states IDLE, GF2MZ, S1S2, RSR, HASH, DONE; status encodes IDLE/DONE as 0, others per REQ-012.
REQ-016 IDLE: start==1 -> GF2MZ, iterate<=0, error<=0; start in any other state SHALL be ignored.
REQ-017 Each sub-block start SHALL be a registered one-cycle pulse in the first cycle of its state; never re-pulsed within the same state visit.
REQ-018 GF2MZ: gf2mz_done -> S1S2.
REQ-019 S1S2: S1S2gen_done -> RSR.
REQ-020 RSR: RSR_done with iterate<D-2 -> S1S2, iterate<=iterate+1; RSR_done with iterate==D-2 -> HASH, iterate held.
REQ-021 HASH: sha3_done -> DONE; DONE lasts exactly one cycle with finish=1, then IDLE.
REQ-022 Latency: start sampled at cycle t -> gf2mz_start=1 at t+1; any done at cycle k -> next start pulse (or finish) at k+1.
REQ-023 Done inputs not matching current state SHALL be ignored and SHALL NOT advance state.
REQ-024 busy SHALL be 1 in GF2MZ, S1S2, RSR, HASH; 0 in IDLE and DONE.
REQ-025 A phase cycle counter SHALL clear on every state change and increment each cycle in a busy state, saturating at TIMEOUT.
REQ-026 Counter reaching TIMEOUT without the matching done -> error<=1, FSM -> IDLE, no finish pulse, iterate<=0.
REQ-027 Done and timeout in the same cycle: done SHALL win (normal transition, error unchanged).
REQ-028 error SHALL stay 1 until the next accepted start or reset.
REQ-029 mat_sel and is_last SHALL be combinational decodes of registered iterate, stable throughout S1S2 and RSR.
REQ-030 Full decryption SHALL produce exactly 1 gf2mz_start, D-1 S1S2gen_start, D-1 RSR_start, 1 sha3_start, 1 finish.

Reset
REQ-031 rst_b==1 SHALL asynchronously force IDLE; status=0, iterate=0, counter=0, busy=0, finish=0, error=0, all *_start=0.
REQ-032 Reset mid-sequence SHALL abort without any start or finish pulse; first start after release SHALL begin a fresh sequence at GF2MZ.

Verification
REQ-033 D=3, each done returned 5 cycles after its start -> status sequence 1,2,3,2,3,4,0; iterate 0,0,1,1; mat_sel 0 then 1; is_last 0 then 1; one finish pulse.
REQ-034 start at t with gf2mz_done at t+4 -> gf2mz_start only at t+1, S1S2gen_start only at t+5, status=2 from t+5.
REQ-035 TIMEOUT=10, RSR_done never asserted -> error=1 and status=0 exactly 10 cycles after RSR_start phase entry; no finish; next start clears error.
REQ-036 sha3_done and spurious RSR_done pulses during S1S2 state -> state unchanged; start pulsed during RSR -> ignored, iterate unchanged.
REQ-037 TIMEOUT=10, S1S2gen_done arriving in the same cycle the counter hits 10 -> transition to RSR, error remains 0.
REQ-038 rst_b asserted for 1 cycle during HASH -> status=0, busy=0 immediately (asynchronous), no finish; subsequent start -> gf2mz_start one cycle later.

Source files
------------

// File: rtl/rollo_decrypt_sched.sv
// ============================================================================
// rollo_decrypt_sched: sequences gf2mz -> (S1S2gen -> RSR) x (D-1) -> SHA3
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rollo_decrypt_sched #(
    parameter int D       = 6,
    parameter int TIMEOUT = 65535,
    parameter int IW      = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    output logic          busy,
    output logic          finish,
    output logic          error,
    output logic          gf2mz_start,
    input  logic          gf2mz_done,
    output logic          S1S2gen_start,
    input  logic          S1S2gen_done,
    output logic          RSR_start,
    input  logic          RSR_done,
    output logic          sha3_start,
    input  logic          sha3_done,
    output logic [2:0]    status,
    output logic [IW-1:0] iterate,
    output logic          mat_sel,
    output logic          is_last
);

    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_ITER = IW'(D - 2);
    localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ABORT = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GF2MZ = 3'd1,
        S_S1S2  = 3'd2,
        S_RSR   = 3'd3,
        S_HASH  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          gf_start_q, gf_start_d;
    logic          s1s2_start_q, s1s2_start_d;
    logic          rsr_start_q, rsr_start_d;
    logic          sha_start_q, sha_start_d;
    logic          fin_q, fin_d;
    logic          busy_w;
    logic          phase_done_w;
    logic          timeout_w;

    // Phase decode: which done input belongs to the current state.
    always_comb begin
        busy_w       = 1'b0;
        status       = 3'd0;
        phase_done_w = 1'b0;
        case (state_q)
            S_GF2MZ: begin busy_w = 1'b1; status = 3'd1; phase_done_w = gf2mz_done;   end
            S_S1S2:  begin busy_w = 1'b1; status = 3'd2; phase_done_w = S1S2gen_done; end
            S_RSR:   begin busy_w = 1'b1; status = 3'd3; phase_done_w = RSR_done;     end
            S_HASH:  begin busy_w = 1'b1; status = 3'd4; phase_done_w = sha3_done;    end
            default: begin busy_w = 1'b0; status = 3'd0; phase_done_w = 1'b0;         end
        endcase
    end

    // The counter would reach TIMEOUT on this edge; a coincident done takes priority.
    assign timeout_w = busy_w && (cnt_q == CNT_ABORT) && !phase_done_w;

    always_comb begin
        state_d      = state_q;
        iter_d       = iter_q;
        err_d        = err_q;
        gf_start_d   = 1'b0;
        s1s2_start_d = 1'b0;
        rsr_start_d  = 1'b0;
        sha_start_d  = 1'b0;
        fin_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_GF2MZ;
                    iter_d     = '0;
                    err_d      = 1'b0;
                    gf_start_d = 1'b1;
                end
            end
            S_GF2MZ: begin
                if (gf2mz_done) begin
                    state_d      = S_S1S2;
                    s1s2_start_d = 1'b1;
                end
            end
            S_S1S2: begin
                if (S1S2gen_done) begin
                    state_d     = S_RSR;
                    rsr_start_d = 1'b1;
                end
            end
            S_RSR: begin
                if (RSR_done) begin
                    if (iter_q == LAST_ITER) begin
                        state_d     = S_HASH;
                        sha_start_d = 1'b1;
                    end else begin
                        state_d      = S_S1S2;
                        iter_d       = iter_q + IW'(1);
                        s1s2_start_d = 1'b1;
                    end
                end
            end
            S_HASH: begin
                if (sha3_done) begin
                    state_d = S_DONE;
                    fin_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (timeout_w) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            iter_d  = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (busy_w && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q      <= S_IDLE;
            iter_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            gf_start_q   <= 1'b0;
            s1s2_start_q <= 1'b0;
            rsr_start_q  <= 1'b0;
            sha_start_q  <= 1'b0;
            fin_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            iter_q       <= iter_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            gf_start_q   <= gf_start_d;
            s1s2_start_q <= s1s2_start_d;
            rsr_start_q  <= rsr_start_d;
            sha_start_q  <= sha_start_d;
            fin_q        <= fin_d;
        end
    end

    assign busy          = busy_w;
    assign finish        = fin_q;
    assign error         = err_q;
    assign gf2mz_start   = gf_start_q;
    assign S1S2gen_start = s1s2_start_q;
    assign RSR_start     = rsr_start_q;
    assign sha3_start    = sha_start_q;
    assign iterate       = iter_q;
    assign mat_sel       = (iter_q != '0);
    assign is_last       = (iter_q == LAST_ITER);

endmodule

`default_nettype wire

// File: tb/tb_rollo_decrypt_sched.sv
// ============================================================================
// tb_rollo_decrypt_sched: vector table, corner sequences and random run vs model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rollo_decrypt_sched;

    localparam int D       = 3;
    localparam int TIMEOUT = 10;
    localparam int IW      = $clog2(D);
    localparam int NVEC    = 17;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          start, gd, sd, rd, hd;
    logic          busy, finish, error;
    logic          gf2mz_start, S1S2gen_start, RSR_start, sha3_start;
    logic [2:0]    status;
    logic [IW-1:0] iterate;
    logic          mat_sel, is_last;

    rollo_decrypt_sched #(.D(D), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .start         (start),
        .busy          (busy),
        .finish        (finish),
        .error         (error),
        .gf2mz_start   (gf2mz_start),
        .gf2mz_done    (gd),
        .S1S2gen_start (S1S2gen_start),
        .S1S2gen_done  (sd),
        .RSR_start     (RSR_start),
        .RSR_done      (rd),
        .sha3_start    (sha3_start),
        .sha3_done     (hd),
        .status        (status),
        .iterate       (iterate),
        .mat_sel       (mat_sel),
        .is_last       (is_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // in = {start, gf2mz_done, S1S2gen_done, RSR_done, sha3_done}
    // p  = {gf2mz_start, S1S2gen_start, RSR_start, sha3_start, finish}
    typedef struct {
        logic [4:0] in;
        int         st;
        int         it;
        logic [4:0] p;
        bit         e;
    } vec_t;

    vec_t tbl [NVEC];

    // reference model state: phase 0 idle, 1..4 working phases, 5 done slot
    int         m_phase, m_age, m_iter;
    bit         m_err;
    logic [4:0] m_pulse;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] v);
        {start, gd, sd, rd, hd} = v;
    endtask

    function automatic logic [31:0] obs();
        return 32'({status, busy, iterate, mat_sel, is_last,
                    gf2mz_start, S1S2gen_start, RSR_start, sha3_start, finish, error});
    endfunction

    function automatic logic [31:0] exp_vec(input int st, input int it, input logic [4:0] p, input bit e);
        logic [2:0]    s3;
        logic [IW-1:0] i2;
        s3 = 3'(st);
        i2 = IW'(it);
        return 32'({s3, (st != 0), i2, (it != 0), (it == D - 2), p, e});
    endfunction

    function automatic logic [4:0] pulses();
        return {gf2mz_start, S1S2gen_start, RSR_start, sha3_start, finish};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_age   = 0;
        m_iter  = 0;
        m_err   = 1'b0;
        m_pulse = '0;
    endtask

    // One clock edge of the sequencer's rules, with m_age = cycles spent in the phase so far.
    task automatic model_step(input logic [4:0] v);
        int nxt;
        bit dn;
        nxt     = m_phase;
        dn      = 1'b0;
        m_pulse = '0;
        case (m_phase)
            0: if (v[4]) begin nxt = 1; m_iter = 0; m_err = 1'b0; end
            1: dn = v[3];
            2: dn = v[2];
            3: dn = v[1];
            4: dn = v[0];
            default: nxt = 0;
        endcase
        if (m_phase >= 1 && m_phase <= 4) begin
            if (dn) begin
                if (m_phase == 3 && m_iter < D - 2) begin
                    nxt = 2;
                    m_iter++;
                end else begin
                    nxt = m_phase + 1;
                end
            end else if (m_age >= TIMEOUT) begin
                nxt    = 0;
                m_err  = 1'b1;
                m_iter = 0;
            end
        end
        if (nxt != m_phase && nxt >= 1) m_pulse[5 - nxt] = 1'b1;
        m_age   = (nxt != m_phase) ? 1 : m_age + 1;
        m_phase = nxt;
    endtask

    initial begin
        int         q_st[$];
        int         q_it[$];
        int         q_ml[$];
        logic [2:0] prev;
        logic [4:0] p, pend, acc;
        logic [2:0] st_acc;
        logic [31:0] pack;
        int         cd;
        int         n_gs, n_ss, n_rs, n_hs, n_fin;
        logic [4:0] v;
        int         est;

        tbl[0]  = '{5'b10000, 1, 0, 5'b10000, 1'b0};
        tbl[1]  = '{5'b10000, 1, 0, 5'b00000, 1'b0};
        tbl[2]  = '{5'b00110, 1, 0, 5'b00000, 1'b0};
        tbl[3]  = '{5'b00000, 1, 0, 5'b00000, 1'b0};
        tbl[4]  = '{5'b01000, 2, 0, 5'b01000, 1'b0};
        tbl[5]  = '{5'b00011, 2, 0, 5'b00000, 1'b0};
        tbl[6]  = '{5'b00100, 3, 0, 5'b00100, 1'b0};
        tbl[7]  = '{5'b00010, 2, 1, 5'b01000, 1'b0};
        tbl[8]  = '{5'b00001, 2, 1, 5'b00000, 1'b0};
        tbl[9]  = '{5'b00100, 3, 1, 5'b00100, 1'b0};
        tbl[10] = '{5'b10000, 3, 1, 5'b00000, 1'b0};
        tbl[11] = '{5'b00010, 4, 1, 5'b00010, 1'b0};
        tbl[12] = '{5'b00000, 4, 1, 5'b00000, 1'b0};
        tbl[13] = '{5'b00001, 0, 1, 5'b00001, 1'b0};
        tbl[14] = '{5'b10000, 0, 1, 5'b00000, 1'b0};
        tbl[15] = '{5'b00000, 0, 1, 5'b00000, 1'b0};
        tbl[16] = '{5'b01000, 0, 1, 5'b00000, 1'b0};

        rst_b = 1'b1;
        drive(5'b0);
        #12;
        check("reset_state", obs(), exp_vec(0, 0, 5'b0, 1'b0));
        @(posedge clk);
        #1;
        rst_b = 1'b0;

        // table: inputs held for one cycle, outputs expected in the following cycle
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].in);
            step();
            check($sformatf("vec%0d", i), obs(), exp_vec(tbl[i].st, tbl[i].it, tbl[i].p, tbl[i].e));
        end
        drive(5'b0);

        // full run, each done returned 5 cycles after its start pulse
        n_gs = 0; n_ss = 0; n_rs = 0; n_hs = 0; n_fin = 0;
        cd = 0; pend = '0; prev = 3'd0;
        drive(5'b10000);
        step();
        drive(5'b0);
        for (int c = 0; c < 80; c++) begin
            p = pulses();
            n_gs += int'(p[4]); n_ss += int'(p[3]); n_rs += int'(p[2]);
            n_hs += int'(p[1]); n_fin += int'(p[0]);
            if (status != prev) begin
                q_st.push_back(int'(status));
                if (status == 3'd2 || status == 3'd3) begin
                    q_it.push_back(int'(iterate));
                    q_ml.push_back(int'({mat_sel, is_last}));
                end
                prev = status;
            end
            if (cd > 0) cd--;
            if (p[4:1] != 4'b0) begin
                cd   = 5;
                pend = {1'b0, p[4:1]};
            end
            drive(cd == 1 ? pend : 5'b0);
            step();
        end
        drive(5'b0);
        check("a_status_count", 32'(q_st.size()), 32'd7);
        pack = '0;
        foreach (q_st[i]) pack = (pack << 3) | 32'(q_st[i]);
        check("a_status_seq", pack, 32'o1232340);
        pack = '0;
        foreach (q_it[i]) pack = (pack << 2) | 32'(q_it[i]);
        check("a_iter_seq", pack, 32'h05);
        pack = '0;
        foreach (q_ml[i]) pack = (pack << 2) | 32'(q_ml[i]);
        check("a_matsel_islast_seq", pack, 32'h0F);
        check("a_pulse_counts", 32'({4'(n_gs), 4'(n_ss), 4'(n_rs), 4'(n_hs), 4'(n_fin)}), 32'h12211);
        check("a_end_idle", 32'({status, busy, error}), 32'd0);

        // timeout in the second RSR round
        drive(5'b10000); step();
        drive(5'b01000); step();
        drive(5'b00100); step();
        drive(5'b00010); step();
        drive(5'b00100); step();
        drive(5'b0);
        check("b_rsr_entry", obs(), exp_vec(3, 1, 5'b00100, 1'b0));
        repeat (9) step();
        check("b_pre_timeout", obs(), exp_vec(3, 1, 5'b0, 1'b0));
        step();
        check("b_timeout", obs(), exp_vec(0, 0, 5'b0, 1'b1));
        repeat (3) step();
        check("b_error_sticky", obs(), exp_vec(0, 0, 5'b0, 1'b1));
        drive(5'b10000); step();
        drive(5'b0);
        check("b_restart_clears", obs(), exp_vec(1, 0, 5'b10000, 1'b0));

        // S1S2 done coincides with the last allowed cycle
        drive(5'b01000); step();
        drive(5'b0);
        check("c_s1s2_entry", obs(), exp_vec(2, 0, 5'b01000, 1'b0));
        repeat (9) step();
        check("c_pre_limit", obs(), exp_vec(2, 0, 5'b0, 1'b0));
        drive(5'b00100); step();
        drive(5'b0);
        check("c_done_wins", obs(), exp_vec(3, 0, 5'b00100, 1'b0));

        // asynchronous reset during HASH
        drive(5'b00010); step();
        drive(5'b00100); step();
        drive(5'b00010); step();
        drive(5'b0);
        check("d_hash", obs(), exp_vec(4, 1, 5'b00010, 1'b0));
        #3;
        rst_b = 1'b1;
        #1;
        check("d_async_reset", obs(), exp_vec(0, 0, 5'b0, 1'b0));
        @(posedge clk);
        #2;
        rst_b  = 1'b0;
        drive(5'b00001);
        acc    = '0;
        st_acc = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            drive(5'b0);
            acc    = acc | pulses();
            st_acc = st_acc | status;
        end
        check("d_quiet_after_reset", 32'({st_acc, acc}), 32'd0);
        drive(5'b10000); step();
        drive(5'b0);
        check("d_restart", obs(), exp_vec(1, 0, 5'b10000, 1'b0));

        // random stimulus against the model
        #1;
        rst_b = 1'b1;
        #2;
        rst_b = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            v[4] = ($urandom_range(3) == 0);
            v[3] = ($urandom_range(6) == 0);
            v[2] = ($urandom_range(6) == 0);
            v[1] = ($urandom_range(6) == 0);
            v[0] = ($urandom_range(6) == 0);
            drive(v);
            step();
            model_step(v);
            est = (m_phase >= 1 && m_phase <= 4) ? m_phase : 0;
            check($sformatf("rand%0d", c), obs(), exp_vec(est, m_iter, m_pulse, m_err));
        end
        drive(5'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
